// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: state encodings and divider handshake constants shared by the divide sequencer.
package div_ctrl_pkg;
    typedef enum logic [1:0] {DivCtrlIdle, DivCtrlBusy, DivCtrlDone, DivCtrlAbort} div_ctrl_state_e;
    localparam logic DivStart = 1'b1;
    localparam logic DivStop = 1'b0;
    localparam logic DivResultReady = 1'b1;
    localparam int DivTimeoutDefault = 48;
endpackage

// File: rtl/div_ctrl.sv
// div_ctrl: sequences EX divide requests through the iterative divider, stalling EX
// until the result is ready and holding HI/LO until the instruction advances.
module div_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int TIMEOUT = DivTimeoutDefault,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_div_req_i,
    input  logic             ex_signed_i,
    input  logic [31:0]      ex_op1_i,
    input  logic [31:0]      ex_op2_i,
    input  logic             ex_stall_i,
    input  logic             flush_i,
    input  logic [63:0]      div_result_i,
    input  logic             div_ready_i,
    output logic [31:0]      div_opdata1_o,
    output logic [31:0]      div_opdata2_o,
    output logic             div_signed_o,
    output logic             div_start_o,
    output logic             div_annul_o,
    output logic             stallreq_o,
    output logic [31:0]      hi_o,
    output logic [31:0]      lo_o,
    output logic             result_valid_o,
    output logic             div_by_zero_o,
    output logic             timeout_err_o,
    output logic [CNT_W-1:0] div_count_o
);
    localparam int WD_W = $clog2(TIMEOUT + 1);

    div_ctrl_state_e state_q, state_d;
    logic [31:0] op1_q, op1_d, op2_q, op2_d, hi_q, hi_d, lo_q, lo_d;
    logic signed_q, signed_d, dbz_q, dbz_d, dbz_out_q, dbz_out_d;
    logic to_err_q, to_err_d, drain_q, drain_d;
    logic [WD_W-1:0] wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic timeout;

    assign timeout = (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivCtrlIdle;
            op1_q     <= '0;
            op2_q     <= '0;
            signed_q  <= 1'b0;
            dbz_q     <= 1'b0;
            dbz_out_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            to_err_q  <= 1'b0;
            drain_q   <= 1'b0;
            wd_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op1_q     <= op1_d;
            op2_q     <= op2_d;
            signed_q  <= signed_d;
            dbz_q     <= dbz_d;
            dbz_out_q <= dbz_out_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            to_err_q  <= to_err_d;
            drain_q   <= drain_d;
            wd_q      <= wd_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op1_d       = op1_q;
        op2_d       = op2_q;
        signed_d    = signed_q;
        dbz_d       = dbz_q;
        dbz_out_d   = dbz_out_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        to_err_d    = to_err_q;
        drain_d     = drain_q;
        wd_d        = wd_q;
        cnt_d       = cnt_q;
        div_start_o = DivStop;
        div_annul_o = 1'b0;
        stallreq_o  = 1'b0;
        case (state_q)
            DivCtrlIdle: begin
                if (ex_div_req_i && !flush_i) begin
                    op1_d      = ex_op1_i;
                    op2_d      = ex_op2_i;
                    signed_d   = ex_signed_i;
                    dbz_d      = (ex_op2_i == 32'd0);
                    wd_d       = '0;
                    stallreq_o = 1'b1;
                    state_d    = DivCtrlBusy;
                end
            end
            DivCtrlBusy: begin
                div_start_o = DivStart;
                stallreq_o  = 1'b1;
                wd_d        = wd_q + 1'b1;
                // flush outranks the watchdog, so only an unflushed expiry is an error
                if (flush_i || timeout) begin
                    div_start_o = DivStop;
                    div_annul_o = 1'b1;
                    to_err_d    = to_err_q | ~flush_i;
                    drain_d     = 1'b0;
                    state_d     = DivCtrlAbort;
                end else if (div_ready_i == DivResultReady) begin
                    hi_d      = div_result_i[63:32];
                    lo_d      = div_result_i[31:0];
                    dbz_out_d = dbz_q;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = DivCtrlDone;
                end
            end
            DivCtrlDone: state_d = (flush_i || !ex_stall_i) ? DivCtrlIdle : DivCtrlDone;
            DivCtrlAbort: begin
                stallreq_o = ex_div_req_i;
                drain_d    = 1'b1;
                state_d    = drain_q ? DivCtrlIdle : DivCtrlAbort;
            end
            default: state_d = DivCtrlIdle;
        endcase
    end

    assign div_opdata1_o  = op1_q;
    assign div_opdata2_o  = op2_q;
    assign div_signed_o   = signed_q;
    assign hi_o           = hi_q;
    assign lo_o           = lo_q;
    assign result_valid_o = (state_q == DivCtrlDone);
    assign div_by_zero_o  = dbz_out_q;
    assign timeout_err_o  = to_err_q;
    assign div_count_o    = cnt_q;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed vectors for div_ctrl against a behavioural 32-iteration divider
// (ready on the 36th start cycle, or the 4th for a zero divisor).
module tb_div_ctrl;
    logic        clk = 1'b0, rst = 1'b0;
    logic        ex_div_req_i = 1'b0, ex_signed_i = 1'b0, ex_stall_i = 1'b0, flush_i = 1'b0;
    logic [31:0] ex_op1_i = '0, ex_op2_i = '0;
    logic [63:0] div_result_i;
    logic        div_ready_i;
    logic [31:0] div_opdata1_o, div_opdata2_o, hi_o, lo_o;
    logic        div_signed_o, div_start_o, div_annul_o, stallreq_o;
    logic        result_valid_o, div_by_zero_o, timeout_err_o;
    logic [31:0] div_count_o;

    div_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_div_req_i(ex_div_req_i), .ex_signed_i(ex_signed_i),
        .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .div_result_i(div_result_i), .div_ready_i(div_ready_i),
        .div_opdata1_o(div_opdata1_o), .div_opdata2_o(div_opdata2_o),
        .div_signed_o(div_signed_o), .div_start_o(div_start_o),
        .div_annul_o(div_annul_o), .stallreq_o(stallreq_o),
        .hi_o(hi_o), .lo_o(lo_o), .result_valid_o(result_valid_o),
        .div_by_zero_o(div_by_zero_o), .timeout_err_o(timeout_err_o),
        .div_count_o(div_count_o)
    );

    always #5 clk = ~clk;

    // Divider model: counts consecutive start cycles; kill suppresses ready.
    logic [6:0] dcnt = '0;
    logic       kill = 1'b0;
    always @(posedge clk) dcnt <= div_start_o ? dcnt + 7'd1 : 7'd0;
    always_comb begin
        div_ready_i = div_start_o && !kill && (dcnt == ((div_opdata2_o == 32'd0) ? 7'd3 : 7'd35));
        if (div_opdata2_o == 32'd0)
            div_result_i = '0;
        else if (div_signed_o)
            div_result_i = {$signed(div_opdata1_o) % $signed(div_opdata2_o), $signed(div_opdata1_o) / $signed(div_opdata2_o)};
        else
            div_result_i = {div_opdata1_o % div_opdata2_o, div_opdata1_o / div_opdata2_o};
    end

    typedef struct {
        logic        sgn;
        logic [31:0] a, b;
        int          hold;
        logic [31:0] lo, hi;
        logic        dbz;
        int          lat;
    } vec_t;

    vec_t vecs[5];
    vec_t v93, vflush, vto;
    int errs = 0, checks = 0, exp_cnt = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(vec_t v);
        @(negedge clk);
        ex_signed_i  = v.sgn;
        ex_op1_i     = v.a;
        ex_op2_i     = v.b;
        ex_div_req_i = 1'b1;
        ex_stall_i   = 1'b0;
        #1;
    endtask

    task automatic finish(vec_t v, int lat, int skip);
        int n = 0;
        bit bad = 1'b0;
        while (stallreq_o && n < 200) begin
            if (n >= skip && (div_start_o !== 1'b1 || div_opdata1_o !== v.a ||
                              div_opdata2_o !== v.b || div_signed_o !== v.sgn))
                bad = 1'b1;
            n++;
            @(negedge clk); #1;
        end
        chk("stall_len", 64'(n), 64'(lat));
        chk("busy_hold", 64'(bad), 64'd0);
        for (int i = 0; i <= v.hold; i++) begin
            ex_stall_i = (i < v.hold);
            chk("done_valid", 64'(result_valid_o), 64'd1);
            chk("done_lo", 64'(lo_o), 64'(v.lo));
            chk("done_hi", 64'(hi_o), 64'(v.hi));
            chk("done_dbz", 64'(div_by_zero_o), 64'(v.dbz));
            chk("done_start", 64'(div_start_o), 64'd0);
            chk("done_count", 64'(div_count_o), 64'(exp_cnt + 1));
            if (i < v.hold) begin
                @(negedge clk); #1;
            end
        end
        exp_cnt++;
        @(negedge clk);
        ex_div_req_i = 1'b0;
        ex_stall_i   = 1'b0;
        #1;
        chk("post_valid", 64'(result_valid_o), 64'd0);
        chk("post_stall", 64'(stallreq_o), 64'd0);
    endtask

    task automatic run_vec(vec_t v);
        issue(v);
        finish(v, v.lat, 1);
    endtask

    initial begin
        vecs[0] = '{1'b0, 32'd100, 32'd7, 0, 32'd14, 32'd2, 1'b0, 37};
        vecs[1] = '{1'b1, 32'hFFFF_FFF9, 32'd2, 5, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 37};
        vecs[2] = '{1'b0, 32'd5, 32'd0, 0, 32'd0, 32'd0, 1'b1, 5};
        vecs[3] = '{1'b1, 32'd100, 32'hFFFF_FFF9, 2, 32'hFFFF_FFF2, 32'd2, 1'b0, 37};
        vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd16, 0, 32'h0FFF_FFFF, 32'd15, 1'b0, 37};
        v93     = '{1'b0, 32'd9, 32'd3, 0, 32'd3, 32'd0, 1'b0, 37};
        vflush  = '{1'b0, 32'd1000, 32'd3, 0, 32'd333, 32'd1, 1'b0, 37};
        vto     = '{1'b0, 32'd50, 32'd5, 0, 32'd10, 32'd0, 1'b0, 37};

        #1;
        chk("rst_count", 64'(div_count_o), 64'd0);
        chk("rst_hilo", {hi_o, lo_o}, 64'd0);
        chk("rst_ctl", 64'({div_start_o, div_annul_o, stallreq_o, result_valid_o, timeout_err_o}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        for (int k = 0; k < 5; k++) run_vec(vecs[k]);

        // flush on the 10th busy cycle, then a divide issued during the second abort cycle
        issue(vflush);
        repeat (10) @(negedge clk);
        flush_i = 1'b1;
        #1;
        chk("flush_annul", 64'(div_annul_o), 64'd1);
        chk("flush_start", 64'(div_start_o), 64'd0);
        @(negedge clk);
        flush_i = 1'b0;
        ex_div_req_i = 1'b0;
        #1;
        chk("abort1_annul", 64'(div_annul_o), 64'd0);
        chk("abort1_stall", 64'(stallreq_o), 64'd0);
        @(negedge clk);
        ex_signed_i = v93.sgn; ex_op1_i = v93.a; ex_op2_i = v93.b; ex_div_req_i = 1'b1;
        #1;
        chk("abort2_stall", 64'(stallreq_o), 64'd1);
        chk("abort2_start", 64'({div_start_o, result_valid_o}), 64'd0);
        @(negedge clk); #1;
        chk("idle_start", 64'(div_start_o), 64'd0);
        @(negedge clk); #1;
        chk("busy1_start", 64'(div_start_o), 64'd1);
        finish(v93, 36, 0);

        // watchdog: divider never answers
        kill = 1'b1;
        issue(vto);
        begin
            int n = 0;
            while (!div_annul_o && n < 200) begin
                n++;
                @(negedge clk); #1;
            end
            chk("to_len", 64'(n), 64'd48);
        end
        ex_div_req_i = 1'b0;
        @(negedge clk); #1;
        chk("to_err", 64'(timeout_err_o), 64'd1);
        chk("to_annul_off", 64'(div_annul_o), 64'd0);
        chk("to_count", 64'(div_count_o), 64'(exp_cnt));
        kill = 1'b0;
        @(negedge clk);
        run_vec(v93);
        chk("to_sticky", 64'(timeout_err_o), 64'd1);

        // async reset in the middle of BUSY
        issue(vecs[0]);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        ex_div_req_i = 1'b0;
        #1;
        chk("arst_ops", {div_opdata1_o, div_opdata2_o}, 64'd0);
        chk("arst_hilo", {hi_o, lo_o}, 64'd0);
        chk("arst_ctl", 64'({div_signed_o, div_start_o, div_annul_o, stallreq_o,
                             result_valid_o, div_by_zero_o, timeout_err_o}), 64'd0);
        chk("arst_count", 64'(div_count_o), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst = 1'b1;
        run_vec(vecs[2]);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencer between the EX stage and the iterative 32-bit divider (DIV/DIVU).
- Accepts a divide request from EX, latches the operands and holds them stable, and drives the divider start/annul/stop handshake.
- Stalls the pipeline until the result is ready, then holds HI/LO until EX advances.
- Handles flush (annul), divide-by-zero flagging, a busy watchdog and a completion counter.

Parameters:
- TIMEOUT, 48, maximum cycles in BUSY before the watchdog aborts the operation.
- CNT_W, 32, width of the completed-divide counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ex_div_req_i  in  1  EX holds a DIV/DIVU instruction.
- ex_signed_i  in  1  1 = DIV, 0 = DIVU.
- ex_op1_i  in  32  dividend.
- ex_op2_i  in  32  divisor.
- ex_stall_i  in  1  EX held by a later stage; the instruction does not advance this cycle.
- flush_i  in  1  pipeline flush; kills the instruction in EX.
- div_result_i  in  64  divider result: {remainder, quotient}.
- div_ready_i  in  1  divider result ready.
- div_opdata1_o  out  32  latched dividend.
- div_opdata2_o  out  32  latched divisor.
- div_signed_o  out  1  latched signed flag.
- div_start_o  out  1  1 = start/hold, 0 = stop.
- div_annul_o  out  1  cancel the running divide.
- stallreq_o  out  1  stall request to pipeline control.
- hi_o  out  32  remainder for HI.
- lo_o  out  32  quotient for LO.
- result_valid_o  out  1  hi_o/lo_o valid for the instruction in EX.
- div_by_zero_o  out  1  current result came from a zero divisor.
- timeout_err_o  out  1  sticky watchdog error.
- div_count_o  out  CNT_W  number of completed divides.

Behaviour:
- Reset (rst low, async): state IDLE. All outputs and registers are 0, including operand latches, hi/lo, counters and flags.
- States: IDLE, BUSY, DONE, ABORT.
- IDLE:
  - If ex_div_req_i=1 and flush_i=0: latch op1, op2 and signed; latch dbz = (op2==0); clear the watchdog; go to BUSY.
  - div_start_o=0 in IDLE.
- BUSY:
  - div_start_o=1; operand outputs held constant, because the divider re-reads them for sign correction.
  - The watchdog increments each cycle.
  - Priority: flush_i, then watchdog reaching TIMEOUT, then div_ready_i.
  - flush_i=1: div_annul_o=1 and div_start_o=0 this cycle; go to ABORT.
  - Watchdog reaches TIMEOUT: set timeout_err_o (sticky until reset); behave as flush.
  - div_ready_i=1: capture hi=div_result_i[63:32] and lo=div_result_i[31:0]; div_by_zero_o <= dbz; increment div_count_o (wraps modulo 2^CNT_W); go to DONE.
- DONE:
  - div_start_o=0, the stop condition, so the divider returns to free this cycle.
  - result_valid_o=1.
  - If flush_i=1, or ex_stall_i=0 (EX advances): clear result_valid_o and go to IDLE.
  - Otherwise hold; hi/lo stay stable for any number of stalled cycles.
- ABORT:
  - Lasts exactly 2 cycles, counted with a 1-bit drain counter.
  - div_start_o=0, div_annul_o=0 after the first cycle; div_ready_i is ignored.
  - Guarantees the divider reaches free even if it was in its zero-divisor or end state. Then go to IDLE. No result is written and div_count_o is unchanged.
- stallreq_o is combinational:
  - (IDLE & ex_div_req_i & !flush_i) | BUSY | (ABORT & ex_div_req_i).
  - Low in DONE.
- Latency: request in IDLE at cycle t, so BUSY from t+1. DONE is entered the cycle after div_ready_i is first seen.
  - Nonzero divisor (32-iteration divider): stallreq_o high t..t+36; DONE at t+37.
  - Zero divisor: stallreq_o high t..t+4; DONE at t+5.
- Back-to-back divides: the DONE→IDLE transition coincides with the next instruction entering EX. It is accepted in IDLE the following cycle, and the divider is already free.
- flush_i in IDLE blocks acceptance. Any request with flush_i=1 is dropped.

Decomposition:
- Shared defines: state encodings (DivCtrlIdle/Busy/Done/Abort).
- Reuse the existing DivStart/DivStop and DivResultReady encodings.
- TIMEOUT default lives beside them.
- No sub-module; the watchdog and drain counters are inline.

Test Plan:
- DIVU 100/7, no stalls -> stallreq_o high 37 cycles; lo_o=14, hi_o=2, result_valid_o 1 cycle, div_count_o=1.
- DIV -7/2 with ex_stall_i held 5 cycles after DONE -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF, stable all 5 cycles, div_start_o=0 throughout DONE.
- DIVU 5/0 -> DONE at t+5; hi_o=lo_o=0, div_by_zero_o=1.
- flush_i at BUSY cycle 10 -> div_annul_o pulse 1 cycle, ABORT 2 cycles, IDLE; a following DIVU 9/3 gives lo_o=3, hi_o=0, div_count_o unchanged by the flushed divide.
- Divider model with div_ready_i tied 0 -> timeout_err_o set after 48 BUSY cycles, annul issued, return to IDLE.
- rst low mid-BUSY -> all outputs 0 immediately (async), state IDLE.
